// File: rtl/usr_shift_reg_n_if.sv
// usr_shift_reg_n_if: control, data and status bundle of the universal shift register.
interface usr_shift_reg_n_if #(parameter int WIDTH = 8);
   localparam int CNT_W = $clog2(WIDTH + 1);
   logic clr;
   logic [2:0] mode;
   logic serial_in_l;
   logic serial_in_r;
   logic [WIDTH-1:0] par_in;
   logic start;
   logic [CNT_W-1:0] burst_len;
   logic [WIDTH-1:0] out;
   logic serial_out_l;
   logic serial_out_r;
   logic busy;
   logic done;
   modport master (
      output clr, mode, serial_in_l, serial_in_r, par_in, start, burst_len,
      input out, serial_out_l, serial_out_r, busy, done
   );
   modport slave (
      input clr, mode, serial_in_l, serial_in_r, par_in, start, burst_len,
      output out, serial_out_l, serial_out_r, busy, done
   );
endinterface

// File: rtl/usr_shift_reg_n.sv
// usr_shift_reg_n: WIDTH-bit universal shift register with a self-timed N-step burst engine.
// Rotate modes are compiled only when USR_ROTATE_EN is defined; otherwise they hold.
module usr_shift_reg_n #(
   parameter int WIDTH = 8
) (
   input logic clk,
   input logic reset_n,
   usr_shift_reg_n_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] out_q, out_n;
   logic [CNT_W-1:0] cnt, cnt_n, len_sat;
   logic [2:0] bmode, bmode_n;
   logic done_q, done_n;
   function automatic logic [WIDTH-1:0] op(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                           input logic sl, input logic sr);
      op = v;
      case (m)
         3'd1: op = {v[WIDTH-2:0], sl};
         3'd2: op = {sr, v[WIDTH-1:1]};
         3'd3: op = bus.par_in;
`ifdef USR_ROTATE_EN
         3'd4: op = {v[WIDTH-2:0], v[WIDTH-1]};
         3'd5: op = {v[0], v[WIDTH-1:1]};
`endif
         3'd6: op = {v[WIDTH-1], v[WIDTH-1:1]};
         3'd7: op = '0;
         default: op = v;
      endcase
   endfunction
   assign len_sat = (bus.burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.burst_len;
   always_comb begin
      state_n = state;
      out_n = out_q;
      cnt_n = cnt;
      bmode_n = bmode;
      done_n = 1'b0;
      if (bus.clr) begin
         state_n = IDLE;
         out_n = '0;
         cnt_n = '0;
      end else if (state == IDLE) begin
         if (bus.start && len_sat != '0) begin
            state_n = BURST;
            bmode_n = bus.mode;
            cnt_n = len_sat;
         end else if (bus.start) begin
            done_n = 1'b1;
         end else begin
            out_n = op(bus.mode, out_q, bus.serial_in_l, bus.serial_in_r);
         end
      end else begin
         out_n = op(bmode, out_q, bus.serial_in_l, bus.serial_in_r);
         cnt_n = cnt - CNT_W'(1);
         state_n = (cnt == CNT_W'(1)) ? IDLE : BURST;
         done_n = (cnt == CNT_W'(1));
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         out_q <= '0;
         cnt <= '0;
         bmode <= '0;
         done_q <= 1'b0;
      end else begin
         state <= state_n;
         out_q <= out_n;
         cnt <= cnt_n;
         bmode <= bmode_n;
         done_q <= done_n;
      end
   end
   assign bus.out = out_q;
   assign bus.serial_out_l = out_q[WIDTH-1];
   assign bus.serial_out_r = out_q[0];
   assign bus.busy = (state == BURST);
   assign bus.done = done_q;
endmodule

// File: tb/tb_usr_shift_reg_n.sv
// tb_usr_shift_reg_n: scenario tasks with a queue scoreboard for usr_shift_reg_n (WIDTH=8).
module tb_usr_shift_reg_n;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] e;
   usr_shift_reg_n_if #(.WIDTH(8)) bus ();
   usr_shift_reg_n #(.WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] v, input logic sl, input logic sr);
`ifdef USR_ROTATE_EN
      if (m == 3'd4) return {v[6:0], v[7]};
      if (m == 3'd5) return {v[0], v[7:1]};
`endif
      return m == 3'd1 ? {v[6:0], sl} : m == 3'd2 ? {sr, v[7:1]} : m == 3'd3 ? bus.par_in :
             m == 3'd6 ? {v[7], v[7:1]} : m == 3'd7 ? 8'h00 : v;
   endfunction
   task automatic load(input logic [7:0] v);
      bus.mode = 3'd3;
      bus.par_in = v;
      tick();
      bus.mode = 3'd0;
   endtask
   task automatic test_reset();
      load(8'h5A);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.burst_len = 4'd5;
      tick();
      bus.start = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      n_cmp++; if (bus.out !== 8'h00) begin $display("FAIL reset_out got %h want 00", bus.out); n_bad++; end
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", bus.busy); n_bad++; end
      n_cmp++; if (bus.done !== 1'b0) begin $display("FAIL reset_done got %b want 0", bus.done); n_bad++; end
      tick();
      reset_n = 1'b1;
      tick();
      exp_q.push_back(8'hA5);
      load(8'hA5);
      e = exp_q.pop_front();
      n_cmp++; if (bus.out !== e) begin $display("FAIL load got %h want %h", bus.out, e); n_bad++; end
      n_cmp++; if ({bus.serial_out_l, bus.serial_out_r} !== 2'b11) begin
         $display("FAIL load_serial got %b want 11", {bus.serial_out_l, bus.serial_out_r}); n_bad++; end
   endtask
   task automatic test_shifts();
      logic [7:0] cur;
      logic [2:0] modes[3] = '{3'd1, 3'd2, 3'd6};
      logic [7:0] exps[3] = '{8'h4A, 8'hA5, 8'hD2};
      bus.serial_in_l = 1'b0;
      bus.serial_in_r = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.mode = modes[i];
         exp_q.push_back(exps[i]);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (bus.out !== e) begin $display("FAIL shift_%0d got %h want %h", i, bus.out, e); n_bad++; end
      end
      cur = 8'hD2;
      for (int i = 0; i < 24; i++) begin
         bus.mode = 3'($urandom_range(0, 7));
         bus.serial_in_l = 1'($urandom);
         bus.serial_in_r = 1'($urandom);
         bus.par_in = 8'($urandom);
         cur = ref_op(bus.mode, cur, bus.serial_in_l, bus.serial_in_r);
         exp_q.push_back(cur);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (bus.out !== e || bus.serial_out_l !== e[7] || bus.serial_out_r !== e[0]) begin
            $display("FAIL rand_mode%0d got %h want %h", bus.mode, bus.out, e); n_bad++; end
      end
      bus.mode = 3'd0;
   endtask
   task automatic test_burst_rotate();
      load(8'h81);
      bus.start = 1'b1;
      bus.mode = 3'd4;
      bus.burst_len = 4'd3;
`ifdef USR_ROTATE_EN
      exp_q.push_back(8'h03); exp_q.push_back(8'h06); exp_q.push_back(8'h0C);
`else
      exp_q.push_back(8'h81); exp_q.push_back(8'h81); exp_q.push_back(8'h81);
`endif
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      n_cmp++; if (bus.out !== 8'h81 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         $display("FAIL rot_start got out=%h busy=%b done=%b want 81/1/0", bus.out, bus.busy, bus.done); n_bad++; end
      for (int i = 1; i <= 3; i++) begin
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (bus.out !== e || bus.busy !== (i < 3) || bus.done !== (i == 3)) begin
            $display("FAIL rot_step%0d got out=%h busy=%b done=%b want %h/%b/%b", i, bus.out, bus.busy, bus.done, e, i < 3, i == 3); n_bad++; end
      end
      tick();
      n_cmp++; if (bus.done !== 1'b0 || bus.out !== e) begin
         $display("FAIL rot_after got done=%b out=%h want 0/%h", bus.done, bus.out, e); n_bad++; end
   endtask
   task automatic test_serialise();
      int dones;
      load(8'hF0);
      bus.start = 1'b1;
      bus.mode = 3'd2;
      bus.burst_len = 4'd8;
      bus.serial_in_r = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, i >= 4});
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         e = exp_q.pop_front();
         n_cmp++; if (bus.serial_out_r !== e[0]) begin
            $display("FAIL ser_bit%0d got %b want %b", i, bus.serial_out_r, e[0]); n_bad++; end
         dones += int'(bus.done);
         tick();
      end
      n_cmp++; if (bus.out !== 8'h00 || bus.done !== 1'b1) begin
         $display("FAIL ser_final got out=%h done=%b want 00/1", bus.out, bus.done); n_bad++; end
      tick();
      dones += int'(bus.done);
      n_cmp++; if (dones !== 0) begin $display("FAIL ser_done_count got %0d extra want 0", dones); n_bad++; end
   endtask
   task automatic test_abort();
      int dones;
      load(8'h3C);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.burst_len = 4'd5;
      bus.serial_in_l = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      tick();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      n_cmp++; if (bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         $display("FAIL abort got out=%h busy=%b done=%b want 00/0/0", bus.out, bus.busy, bus.done); n_bad++; end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         dones += int'(bus.done) + int'(bus.busy);
      end
      n_cmp++; if (dones !== 0 || bus.out !== 8'h00) begin
         $display("FAIL abort_quiet got activity=%0d out=%h want 0/00", dones, bus.out); n_bad++; end
      load(8'h66);
      bus.clr = 1'b1;
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.burst_len = 4'd3;
      tick();
      bus.clr = 1'b0;
      bus.start = 1'b0;
      bus.mode = 3'd0;
      n_cmp++; if (bus.out !== 8'h00 || bus.busy !== 1'b0) begin
         $display("FAIL clr_over_start got out=%h busy=%b want 00/0", bus.out, bus.busy); n_bad++; end
   endtask
   task automatic test_zero_len();
      load(8'h77);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.burst_len = 4'd0;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 8'h77) begin
         $display("FAIL zero_len got done=%b busy=%b out=%h want 1/0/77", bus.done, bus.busy, bus.out); n_bad++; end
      tick();
      n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         $display("FAIL zero_len_after got done=%b busy=%b want 0/0", bus.done, bus.busy); n_bad++; end
   endtask
   task automatic test_saturate();
      int steps;
      load(8'h01);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.serial_in_l = 1'b0;
      bus.burst_len = 4'd15;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      steps = 0;
      while (bus.done !== 1'b1 && steps < 20) begin
         tick();
         steps++;
      end
      n_cmp++; if (steps !== 8) begin $display("FAIL sat_steps got %0d want 8", steps); n_bad++; end
      n_cmp++; if (bus.out !== 8'h00) begin $display("FAIL sat_out got %h want 00", bus.out); n_bad++; end
   endtask
   task automatic test_back_to_back();
      load(8'h00);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.serial_in_l = 1'b1;
      bus.burst_len = 4'd2;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      tick();
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.out !== 8'h03) begin
         $display("FAIL b2b_first got done=%b out=%h want 1/03", bus.done, bus.out); n_bad++; end
      bus.start = 1'b1;
      bus.mode = 3'd2;
      bus.serial_in_r = 1'b0;
      bus.burst_len = 4'd1;
      tick();
      bus.start = 1'b0;
      bus.mode = 3'd0;
      n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.out !== 8'h03) begin
         $display("FAIL b2b_accept got busy=%b done=%b out=%h want 1/0/03", bus.busy, bus.done, bus.out); n_bad++; end
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 8'h01) begin
         $display("FAIL b2b_second got done=%b busy=%b out=%h want 1/0/01", bus.done, bus.busy, bus.out); n_bad++; end
   endtask
   initial begin
      bus.clr = 1'b0;
      bus.mode = 3'd0;
      bus.serial_in_l = 1'b0;
      bus.serial_in_r = 1'b0;
      bus.par_in = 8'h00;
      bus.start = 1'b0;
      bus.burst_len = 4'd0;
      #1;
      n_cmp++; if (bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         $display("FAIL por got out=%h busy=%b done=%b want 00/0/0", bus.out, bus.busy, bus.done); n_bad++; end
      tick();
      reset_n = 1'b1;
      tick();
      test_reset();
      test_shifts();
      test_burst_rotate();
      test_serialise();
      test_abort();
      test_zero_len();
      test_saturate();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/usr_shift_reg_n.md
# usr_shift_reg_n

Parametrised universal shift register with a self-timed burst engine. It extends the 4-bit hold/shift/clear register into a WIDTH-bit datapath with parallel load, rotate and arithmetic-shift modes, dual serial outputs, and an N-step burst mode that shifts autonomously and signals completion. It sits between parallel producers and serial links, and serves as a general-purpose bit-manipulation register.

## Interface
- WIDTH, 8: register width in bits, ≥ 2.
- CNT_W, derived ($clog2(WIDTH+1)): width of the burst-length counter; local, not overridable.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear, highest functional priority
- mode  in  3  operation select (see Operation)
- serial_in_l  in  1  bit entering at bit 0 on shift-left
- serial_in_r  in  1  bit entering at bit WIDTH-1 on shift-right
- par_in  in  WIDTH  parallel load data
- start  in  1  request a burst of burst_len steps
- burst_len  in  CNT_W  number of burst steps, 0..WIDTH
- out  out  WIDTH  register contents
- serial_out_l  out  1  out[WIDTH-1], combinational from out
- serial_out_r  out  1  out[0], combinational from out
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-completion pulse

## Operation
- Mode encoding and next value of out:
  - 000: hold.
  - 001: shl, {out[W-2:0], serial_in_l}.
  - 010: shr, {serial_in_r, out[W-1:1]}.
  - 011: load par_in.
  - 100: rotl, {out[W-2:0], out[W-1]}.
  - 101: rotr, {out[0], out[W-1:1]}.
  - 110: asr, {out[W-1], out[W-1:1]}.
  - 111: clear to 0.
- FSM states: IDLE and BURST.
- IDLE:
  - The mode operation is applied every cycle.
  - start=1 with burst_len≠0: latch mode and burst_len, go to BURST. out holds on the start cycle; the mode operation is not applied.
  - start=1 with burst_len=0: out holds, done pulses the next cycle, busy stays 0, state stays IDLE.
- BURST:
  - The latched mode is applied once per cycle, exactly burst_len times.
  - The mode input and start are ignored.
  - Serial inputs are sampled live on each step.
  - The counter decrements on each step. On the edge performing the final step: busy←0, done←1, state←IDLE.
- clr=1, any state: out←0, counter←0, state←IDLE, busy←0, done←0. An in-flight burst is aborted with no done. clr overrides start in the same cycle.
- burst_len>WIDTH is saturated to WIDTH at latch time.
- All burst modes are legal; hold, load and clear simply repeat.

## Timing
- Reset (async assert, sync-safe deassert): out=0, busy=0, done=0, state=IDLE, counter=0.
- Single-step latency: out reflects the operation one edge after mode is sampled.
- Burst: start sampled at edge E0. Steps occur at edges E1..E(burst_len).
  - busy=1 from after E0 through the cycle before E(burst_len)+.
  - done=1 for exactly the one cycle after E(burst_len); out holds the final value in that cycle.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted, since the state is IDLE.
- reset_n low mid-burst: immediate return to reset values; no done.
- serial_out_l and serial_out_r have no register stage and follow out in the same cycle.

## Configuration
- USR_ROTATE_EN:
  - Defined: modes 100 and 101 perform rotl and rotr as specified.
  - Undefined: rotate logic is not compiled. Modes 100 and 101 behave as hold (000) in both single-step and burst, and a burst in these modes still counts steps and pulses done.

## Test plan
- Reset and load (WIDTH=8): reset_n low mid-run → out=0x00, busy=0 and done=0 immediately; release, mode=011, par_in=0xA5 → out=0xA5 after one edge, serial_out_l=1, serial_out_r=1.
- Single-step shifts: out=0xA5, mode=001, serial_in_l=0 → 0x4A; then mode=010, serial_in_r=1 → 0xA5; then mode=110 → 0xD2.
- Burst rotate (USR_ROTATE_EN defined): out=0x81, start=1, mode=100, burst_len=3, then mode=000 → busy=1 for 3 cycles, out=0x0C with done=1 for one cycle; without the macro → out stays 0x81, done still pulses after 3 cycles.
- Burst serialisation: load 0xF0, start shr, burst_len=8, serial_in_r=0 → serial_out_r sequence 0,0,0,0,1,1,1,1; final out=0x00; done pulses once.
- Abort and edge cases: clr asserted on the 2nd burst step → out=0x00, busy=0, no done; start with burst_len=0 → done next cycle, busy never 1; burst_len=15 → saturates to 8 steps.
